// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous video RAM between two video
// fetch ports (vid0 = VGA, vid1 = HDMI) and the CPU.
//
// Ports:
//   clk, nreset                     clock (clk_vram), async active-low reset
//   vid0_*/vid1_*                   video read: req/addr in, ack/data/valid out
//   cpu_*                           CPU access: req/we/addr/wdata in,
//                                   ack/rdata/rvalid out
//   ram_addr/ram_wdata/ram_we       registered RAM command
//   ram_rdata                       RAM read data, one cycle after the address
//   busy                            state != IDLE
//
// Optional feature: define VRAM_ARB_RR_EN for round-robin between vid0 and vid1.
module vram_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int CPU_WAIT_MAX = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          vid0_req,
    input  logic [AW-1:0] vid0_addr,
    output logic          vid0_ack,
    output logic [DW-1:0] vid0_data,
    output logic          vid0_valid,
    input  logic          vid1_req,
    input  logic [AW-1:0] vid1_addr,
    output logic          vid1_ack,
    output logic [DW-1:0] vid1_data,
    output logic          vid1_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
    localparam logic [1:0] W_V0 = 2'd0, W_V1 = 2'd1, W_CPU = 2'd2;

    state_t     state, state_nx;
    logic [1:0] win;
    logic       win_we;
    logic [3:0] cpu_wait;
    logic       arb, cap, any_req, cpu_force, g0, g1, g_cpu;

    assign arb       = state == IDLE || state == CAPTURE;
    assign cap       = state == CAPTURE;
    assign any_req   = vid0_req || vid1_req || cpu_req;
    assign cpu_force = cpu_wait == 4'(CPU_WAIT_MAX);
    assign g_cpu     = cpu_req && (cpu_force || !(vid0_req || vid1_req));

`ifdef VRAM_ARB_RR_EN
    // last_v1 = 1 when vid1 won the most recent video grant; vid0 then has priority
    logic last_v1;
    assign g0 = !g_cpu && vid0_req && !(vid1_req && !last_v1);
    assign g1 = !g_cpu && vid1_req && !g0;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            last_v1 <= 1'b1;
        else if (arb && (g0 || g1))
            last_v1 <= g1;
    end
`else
    assign g0 = !g_cpu && vid0_req;
    assign g1 = !g_cpu && !vid0_req && vid1_req;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = arb ? (any_req ? ACCESS : IDLE) : (state == ACCESS ? CAPTURE : IDLE);
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vid0_ack   <= 1'b0;
            vid1_ack   <= 1'b0;
            cpu_ack    <= 1'b0;
            vid0_valid <= 1'b0;
            vid1_valid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vid0_data  <= '0;
            vid1_data  <= '0;
            cpu_rdata  <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            win        <= W_V0;
            win_we     <= 1'b0;
            cpu_wait   <= '0;
        end else begin
            vid0_ack   <= arb && g0;
            vid1_ack   <= arb && g1;
            cpu_ack    <= arb && g_cpu;
            ram_we     <= arb && g_cpu && cpu_we;
            // win/win_we still describe the access finishing in CAPTURE here
            vid0_valid <= cap && win == W_V0;
            vid1_valid <= cap && win == W_V1;
            cpu_rvalid <= cap && win == W_CPU && !win_we;
            if (cap && win == W_V0)
                vid0_data <= ram_rdata;
            if (cap && win == W_V1)
                vid1_data <= ram_rdata;
            if (cap && win == W_CPU && !win_we)
                cpu_rdata <= ram_rdata;
            if (arb && any_req) begin
                win      <= g_cpu ? W_CPU : (g0 ? W_V0 : W_V1);
                win_we   <= g_cpu && cpu_we;
                ram_addr <= g_cpu ? cpu_addr : (g0 ? vid0_addr : vid1_addr);
            end
            if (arb && g_cpu)
                ram_wdata <= cpu_wdata;
            if (arb)
                cpu_wait <= (cpu_req && (g0 || g1)) ? (cpu_force ? cpu_wait : cpu_wait + 4'd1) : 4'd0;
        end
    end
endmodule
